rom_dl_sequencer: RTL and testbench

Sequences the ROM download byte stream into the game's memory resources. It decodes each `ioctl` byte's region, buffers it in a small FIFO, and drives the SDRAM `port1`/`port2` toggle handshakes one write at a time. Sound-ROM and background bytes go straight to on-chip BRAM write strobes. It also owns `rom_loaded` and download-completion signalling, and replaces the free-running toggle logic in the `emu` top level.

---
 rtl/rom_dl_pkg.sv | 30 +++
 rtl/rom_dl_sequencer_if.sv | 27 ++
 rtl/rom_dl_fifo.sv | 65 ++++++
 rtl/rom_dl_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and region boundaries for the ROM download sequencer.
package rom_dl_pkg;

    typedef enum logic [1:0] {R_MAIN, R_CSD, R_SPR, R_BG} region_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [24:0] CSD_BASE = 25'h10000;
    localparam logic [24:0] SPR_BASE = 25'h18000;
    localparam logic [24:0] SND_LO   = 25'h0E000;
    localparam logic [24:0] SND_HI   = 25'h11FFF;

    typedef struct packed {
        logic        port_sel;
        logic [22:0] waddr;
        logic [1:0]  ds;
        logic [7:0]  data;
    } fifo_entry_t;

    function automatic region_t decode_region(input logic [24:0] addr, input logic [24:0] bg_base);
        if (addr < CSD_BASE)
            return R_MAIN;
        else if (addr < SPR_BASE)
            return R_CSD;
        else if (addr < bg_base)
            return R_SPR;
        else
            return R_BG;
    endfunction

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// SDRAM toggle-handshake write ports (port1 main/CSD, port2 sprites).
interface rom_dl_sequencer_if;

    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack;
    logic [18:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;

    modport master (
        output port1_req, port1_a, port1_ds, port1_d,
        output port2_req, port2_a, port2_ds, port2_d,
        input  port1_ack, port2_ack
    );

    modport slave (
        input  port1_req, port1_a, port1_ds, port1_d,
        input  port2_req, port2_a, port2_ds, port2_d,
        output port1_ack, port2_ack
    );

endinterface

// File: rtl/rom_dl_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count.
module rom_dl_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count
);

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(1 << FIFO_AW);

    logic [WIDTH-1:0]   mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != DEPTH_C);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes the ROM download stream to SDRAM ports and BRAMs; tracks rom_loaded.
// Optional DL_CHECKSUM_EN adds dl_sum, a 16-bit wrapping sum of accepted bytes.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int          FIFO_AW = 2,
    parameter logic [24:0] BG_BASE = 25'h28000
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      dl_active,
    input  logic                      dl_wr,
    input  logic [24:0]               dl_addr,
    input  logic [7:0]                dl_data,
    output logic                      dl_wait,
    rom_dl_sequencer_if.master        sdram,
    output logic                      snd_we,
    output logic [13:0]               snd_a,
    output logic [7:0]                snd_d,
    output logic                      bg_we,
    output logic [24:0]               bg_a,
    output logic [7:0]                bg_d,
    output logic                      rom_loaded,
    output logic                      dl_done
`ifdef DL_CHECKSUM_EN
    ,
    output logic [15:0]               dl_sum
`endif
);

    localparam int               ENTRY_W    = $bits(fifo_entry_t);
    localparam logic [FIFO_AW:0] WAIT_LEVEL = (FIFO_AW+1)'((1 << FIFO_AW) - 1);

    region_t          region;
    logic             accept, rise, snd_hit, fifo_bound, push, drop, pop;
    logic             fifo_empty, fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic [19:0]      spr_off;
    fifo_entry_t      push_entry, pop_entry;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        req1_q, req1_d, req2_q, req2_d;
    logic [22:0] p1_a_q, p1_a_d;
    logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
    logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
    logic [18:0] p2_a_q, p2_a_d;
    logic        snd_we_q, snd_we_d, bg_we_q, bg_we_d;
    logic [13:0] snd_a_q, snd_a_d;
    logic [7:0]  snd_d_q, snd_d_d, bg_d_q, bg_d_d;
    logic [24:0] bg_a_q, bg_a_d;
    logic        dl_wait_q, dl_wait_d, active_q, active_d, seen_q, seen_d;
    logic        err_q, err_d, rom_loaded_q, rom_loaded_d, dl_done_q, dl_done_d;

    always_comb begin
        region     = decode_region(dl_addr, BG_BASE);
        accept     = dl_wr && dl_active;
        rise       = dl_active && !active_q;
        snd_hit    = accept && (dl_addr >= SND_LO) && (dl_addr <= SND_HI);
        fifo_bound = accept && (region != R_BG);
        push       = fifo_bound && !fifo_full;
        drop       = fifo_bound && fifo_full;
        spr_off    = dl_addr[19:0] - SPR_BASE[19:0];

        push_entry.port_sel = 1'b0;
        push_entry.waddr    = dl_addr[23:1];
        push_entry.ds       = {dl_addr[0], ~dl_addr[0]};
        push_entry.data     = dl_data;
        // CSD swizzle moves addr[14] to bit 0 before the word/byte split.
        case (region)
            R_CSD: begin
                push_entry.waddr = {dl_addr[23:16], dl_addr[15], dl_addr[13:0]};
                push_entry.ds    = {dl_addr[14], ~dl_addr[14]};
            end
            R_SPR: begin
                push_entry.port_sel = 1'b1;
                push_entry.waddr    = {4'b0000, spr_off[19:1]};
                push_entry.ds       = {spr_off[0], ~spr_off[0]};
            end
            default: ;
        endcase
    end

    rom_dl_fifo #(
        .WIDTH   (ENTRY_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        sel_d   = sel_q;
        req1_d  = req1_q;
        req2_d  = req2_q;
        p1_a_d  = p1_a_q;
        p1_ds_d = p1_ds_q;
        p1_d_d  = p1_d_q;
        p2_a_d  = p2_a_q;
        p2_ds_d = p2_ds_q;
        p2_d_d  = p2_d_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    sel_d = pop_entry.port_sel;
                    if (pop_entry.port_sel) begin
                        p2_a_d  = pop_entry.waddr[18:0];
                        p2_ds_d = pop_entry.ds;
                        p2_d_d  = {pop_entry.data, pop_entry.data};
                    end else begin
                        p1_a_d  = pop_entry.waddr;
                        p1_ds_d = pop_entry.ds;
                        p1_d_d  = {pop_entry.data, pop_entry.data};
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_q)
                    req2_d = ~req2_q;
                else
                    req1_d = ~req1_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (sel_q ? (sdram.port2_ack == req2_q) : (sdram.port1_ack == req1_q))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snd_we_d  = snd_hit;
        snd_a_d   = snd_hit ? {~dl_addr[13], dl_addr[12:0]} : snd_a_q;
        snd_d_d   = snd_hit ? dl_data : snd_d_q;
        bg_we_d   = accept && (region == R_BG);
        bg_a_d    = bg_we_d ? (dl_addr - BG_BASE) : bg_a_q;
        bg_d_d    = bg_we_d ? dl_data : bg_d_q;
        dl_wait_d = (fifo_count >= WAIT_LEVEL);
        active_d  = dl_active;
        seen_d    = seen_q || dl_active;
        err_d     = (err_q && !rise) || drop;
        rom_loaded_d = rom_loaded_q;
        if (rise)
            rom_loaded_d = 1'b0;
        else if (!dl_active && seen_q && fifo_empty && (state_q == IDLE) && !err_q)
            rom_loaded_d = 1'b1;
        dl_done_d = rom_loaded_d && !rom_loaded_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            req1_q       <= 1'b0;
            req2_q       <= 1'b0;
            p1_a_q       <= '0;
            p1_ds_q      <= '0;
            p1_d_q       <= '0;
            p2_a_q       <= '0;
            p2_ds_q      <= '0;
            p2_d_q       <= '0;
            snd_we_q     <= 1'b0;
            snd_a_q      <= '0;
            snd_d_q      <= '0;
            bg_we_q      <= 1'b0;
            bg_a_q       <= '0;
            bg_d_q       <= '0;
            dl_wait_q    <= 1'b0;
            active_q     <= 1'b0;
            seen_q       <= 1'b0;
            err_q        <= 1'b0;
            rom_loaded_q <= 1'b0;
            dl_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            req1_q       <= req1_d;
            req2_q       <= req2_d;
            p1_a_q       <= p1_a_d;
            p1_ds_q      <= p1_ds_d;
            p1_d_q       <= p1_d_d;
            p2_a_q       <= p2_a_d;
            p2_ds_q      <= p2_ds_d;
            p2_d_q       <= p2_d_d;
            snd_we_q     <= snd_we_d;
            snd_a_q      <= snd_a_d;
            snd_d_q      <= snd_d_d;
            bg_we_q      <= bg_we_d;
            bg_a_q       <= bg_a_d;
            bg_d_q       <= bg_d_d;
            dl_wait_q    <= dl_wait_d;
            active_q     <= active_d;
            seen_q       <= seen_d;
            err_q        <= err_d;
            rom_loaded_q <= rom_loaded_d;
            dl_done_q    <= dl_done_d;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = rise ? 16'h0000 : sum_q;
        if (accept && !drop)
            sum_d = sum_d + {8'h00, dl_data};
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign dl_sum = sum_q;
`endif

    assign sdram.port1_req = req1_q;
    assign sdram.port1_a   = p1_a_q;
    assign sdram.port1_ds  = p1_ds_q;
    assign sdram.port1_d   = p1_d_q;
    assign sdram.port2_req = req2_q;
    assign sdram.port2_a   = p2_a_q;
    assign sdram.port2_ds  = p2_ds_q;
    assign sdram.port2_d   = p2_d_q;
    assign dl_wait    = dl_wait_q;
    assign snd_we     = snd_we_q;
    assign snd_a      = snd_a_q;
    assign snd_d      = snd_d_q;
    assign bg_we      = bg_we_q;
    assign bg_a       = bg_a_q;
    assign bg_d       = bg_d_q;
    assign rom_loaded = rom_loaded_q;
    assign dl_done    = dl_done_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer; the bench plays the SDRAM toggle-ack side.
// Build with DL_CHECKSUM_EN defined to also check dl_sum.
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        snd_we;
    logic [13:0] snd_a;
    logic [7:0]  snd_d;
    logic        bg_we;
    logic [24:0] bg_a;
    logic [7:0]  bg_d;
    logic        rom_loaded;
    logic        dl_done;
`ifdef DL_CHECKSUM_EN
    logic [15:0] dl_sum;
    logic [15:0] expSum = 16'h0000;
`endif

    int   checkCount = 0;
    int   failCount  = 0;
    logic expReq1 = 1'b0;
    logic expReq2 = 1'b0;

    rom_dl_sequencer_if sdram_if();

    always #5 clk_sys = ~clk_sys;

    rom_dl_sequencer #(
        .FIFO_AW (2),
        .BG_BASE (25'h28000)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .sdram      (sdram_if),
        .snd_we     (snd_we),
        .snd_a      (snd_a),
        .snd_d      (snd_d),
        .bg_we      (bg_we),
        .bg_a       (bg_a),
        .bg_d       (bg_d),
        .rom_loaded (rom_loaded),
        .dl_done    (dl_done)
`ifdef DL_CHECKSUM_EN
        ,
        .dl_sum     (dl_sum)
`endif
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
        dl_wr   = 1'b1;
        dl_addr = addr;
        dl_data = data;
`ifdef DL_CHECKSUM_EN
        if (dl_active)
            expSum = expSum + {8'h00, data};
`endif
        tick();
        dl_wr = 1'b0;
    endtask

    // Waits for the next request toggle on a port, checks the write, then acks it.
    task automatic sdramCommit(input logic port, input logic [22:0] expA, input logic [1:0] expDs,
                               input logic [7:0] expByte, input string tag);
        int   n;
        logic curReq, wantReq;
        n = 0;
        if (port) expReq2 = ~expReq2;
        else      expReq1 = ~expReq1;
        wantReq = port ? expReq2 : expReq1;
        curReq  = port ? sdram_if.port2_req : sdram_if.port1_req;
        while (curReq !== wantReq && n < 80) begin
            tick();
            n++;
            curReq = port ? sdram_if.port2_req : sdram_if.port1_req;
        end
        checkOutput({tag, "_req"}, 32'(curReq), 32'(wantReq));
        if (port) begin
            checkOutput({tag, "_a"},  32'(sdram_if.port2_a),  32'(expA));
            checkOutput({tag, "_ds"}, 32'(sdram_if.port2_ds), 32'(expDs));
            checkOutput({tag, "_d"},  32'(sdram_if.port2_d),  32'({expByte, expByte}));
            sdram_if.port2_ack = expReq2;
        end else begin
            checkOutput({tag, "_a"},  32'(sdram_if.port1_a),  32'(expA));
            checkOutput({tag, "_ds"}, 32'(sdram_if.port1_ds), 32'(expDs));
            checkOutput({tag, "_d"},  32'(sdram_if.port1_d),  32'({expByte, expByte}));
            sdram_if.port1_ack = expReq1;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int doneCount;

        reset              = 1'b1;
        dl_active          = 1'b0;
        dl_wr              = 1'b0;
        dl_addr            = '0;
        dl_data            = '0;
        sdram_if.port1_ack = 1'b0;
        sdram_if.port2_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        checkOutput("rst_req1",    32'(sdram_if.port1_req), 32'h0);
        checkOutput("rst_req2",    32'(sdram_if.port2_req), 32'h0);
        checkOutput("rst_dl_wait", 32'(dl_wait),            32'h0);
        checkOutput("rst_snd_we",  32'(snd_we),             32'h0);
        checkOutput("rst_bg_we",   32'(bg_we),              32'h0);
        checkOutput("rst_loaded",  32'(rom_loaded),         32'h0);
        checkOutput("rst_done",    32'(dl_done),            32'h0);
        checkOutput("rst_p1_a",    32'(sdram_if.port1_a),   32'h0);

        dl_active = 1'b1;
        tick();

        // 0xA5 at 0x00003: pop one cycle after push, request toggle one cycle after that.
        applyStimulus(25'h00003, 8'hA5);
        tick();
        checkOutput("main_a",        32'(sdram_if.port1_a),   32'h1);
        checkOutput("main_ds",       32'(sdram_if.port1_ds),  32'h2);
        checkOutput("main_d",        32'(sdram_if.port1_d),   32'hA5A5);
        checkOutput("main_req_early", 32'(sdram_if.port1_req), 32'h0);
        tick();
        expReq1 = 1'b1;
        checkOutput("main_req_toggle", 32'(sdram_if.port1_req), 32'h1);
        applyStimulus(25'h00004, 8'h5A);
        tick();
        tick();
        checkOutput("hold_until_ack_a", 32'(sdram_if.port1_a),   32'h1);
        checkOutput("hold_until_ack_r", 32'(sdram_if.port1_req), 32'h1);
        sdram_if.port1_ack = 1'b1;
        sdramCommit(1'b0, 23'h000002, 2'b01, 8'h5A, "main2");

        // 0x14001 swizzles to 0x10003 -> word 0x8001, upper byte.
        applyStimulus(25'h14001, 8'h3C);
        sdramCommit(1'b0, 23'h008001, 2'b10, 8'h3C, "csd");

        // 0x0E005 -> sound BRAM {~a13, a[12:0]} = 0x0005 and port1 word 0x7002.
        applyStimulus(25'h0E005, 8'h77);
        checkOutput("snd_we", 32'(snd_we), 32'h1);
        checkOutput("snd_a",  32'(snd_a),  32'h0005);
        checkOutput("snd_d",  32'(snd_d),  32'h77);
        tick();
        checkOutput("snd_we_pulse", 32'(snd_we), 32'h0);
        sdramCommit(1'b0, 23'h007002, 2'b10, 8'h77, "snd_p1");

        applyStimulus(25'h18000, 8'h11);
        sdramCommit(1'b1, 23'h000000, 2'b01, 8'h11, "spr");

        applyStimulus(25'h28010, 8'h22);
        checkOutput("bg_we", 32'(bg_we), 32'h1);
        checkOutput("bg_a",  32'(bg_a),  32'h10);
        checkOutput("bg_d",  32'(bg_d),  32'h22);
        repeat (4) tick();
        checkOutput("bg_we_pulse", 32'(bg_we),              32'h0);
        checkOutput("bg_no_req1",  32'(sdram_if.port1_req), 32'(expReq1));
        checkOutput("bg_no_req2",  32'(sdram_if.port2_req), 32'(expReq2));

        // Six back-to-back bytes with the ack held off for 40 cycles.
        fork
            begin
                int w;
                for (int i = 0; i < 6; i++) begin
                    w = 0;
                    while (dl_wait && w < 300) begin
                        tick();
                        w++;
                    end
                    if (w >= 300)
                        checkOutput("stream_wait_stuck", 32'(dl_wait), 32'h0);
                    applyStimulus(25'(32'h100 + i), 8'(32'h60 + i));
                    if (i == 4)
                        checkOutput("stream_dl_wait_hi", 32'(dl_wait), 32'h1);
                end
            end
            begin
                repeat (40) tick();
                for (int j = 0; j < 6; j++)
                    sdramCommit(1'b0, 23'(32'h80 + j / 2), (j % 2 == 1) ? 2'b10 : 2'b01,
                                8'(32'h60 + j), "stream");
            end
        join
        tick();
        checkOutput("stream_dl_wait_lo", 32'(dl_wait), 32'h0);

        // Drop dl_active with two writes still pending.
        checkOutput("loaded_while_active", 32'(rom_loaded), 32'h0);
        applyStimulus(25'h00200, 8'h91);
        applyStimulus(25'h00201, 8'h92);
        dl_active = 1'b0;
        repeat (5) tick();
        checkOutput("loaded_pending", 32'(rom_loaded), 32'h0);
        sdramCommit(1'b0, 23'h000100, 2'b01, 8'h91, "tail0");
        checkOutput("loaded_one_left", 32'(rom_loaded), 32'h0);
        sdramCommit(1'b0, 23'h000100, 2'b10, 8'h92, "tail1");
        doneCount = 0;
        for (int k = 0; k < 10; k++) begin
            if (dl_done)
                doneCount++;
            tick();
        end
        checkOutput("done_pulses", 32'(doneCount),  32'h1);
        checkOutput("loaded_set",  32'(rom_loaded), 32'h1);

        applyStimulus(25'h28020, 8'h33);
        checkOutput("inactive_ignored", 32'(bg_we), 32'h0);
`ifdef DL_CHECKSUM_EN
        checkOutput("dl_sum", 32'(dl_sum), 32'(expSum));
`endif

        dl_active = 1'b1;
        tick();
        tick();
        checkOutput("loaded_cleared_rise", 32'(rom_loaded), 32'h0);

        // Abandon a write in WAIT via reset; the ack side re-aligns to zero too.
        applyStimulus(25'h00300, 8'h44);
        expReq1 = ~expReq1;
        n = 0;
        while (sdram_if.port1_req !== expReq1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("midwait_req", 32'(sdram_if.port1_req), 32'(expReq1));
        reset              = 1'b1;
        sdram_if.port1_ack = 1'b0;
        sdram_if.port2_ack = 1'b0;
        expReq1            = 1'b0;
        expReq2            = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst2_req1",   32'(sdram_if.port1_req), 32'h0);
        checkOutput("rst2_req2",   32'(sdram_if.port2_req), 32'h0);
        checkOutput("rst2_p1_a",   32'(sdram_if.port1_a),   32'h0);
        checkOutput("rst2_p1_ds",  32'(sdram_if.port1_ds),  32'h0);
        checkOutput("rst2_p1_d",   32'(sdram_if.port1_d),   32'h0);
        checkOutput("rst2_p2_d",   32'(sdram_if.port2_d),   32'h0);
        checkOutput("rst2_bg_a",   32'(bg_a),               32'h0);
        checkOutput("rst2_snd_a",  32'(snd_a),              32'h0);
        checkOutput("rst2_wait",   32'(dl_wait),            32'h0);
        checkOutput("rst2_loaded", 32'(rom_loaded),         32'h0);
        checkOutput("rst2_done",   32'(dl_done),            32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
